// File: rtl/param_control_unit.sv
// Parametrised calculator sequencer: opcode select, NUM_OPS operand loads, execute, display.
// Define CU_DEBOUNCE_EN to filter ENTER/BACK through a DB_CYCLES stability counter.
module param_control_unit #(
  parameter int NUM_OPS   = 2,
  parameter int STATE_W   = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               CLR,
  input  logic               ENTER,
  input  logic               BACK,
  input  logic [1:0]         MODE,
  output logic               RESET,
  output logic               LoadOU,
  output logic [NUM_OPS-1:0] LoadOp,
  output logic               LoadR,
  output logic               IUAU,
  output logic [1:0]         OpCode,
  output logic               Busy,
  output logic [STATE_W-1:0] LEDR
);

  if (NUM_OPS < 1 || NUM_OPS > 8 || (2 ** STATE_W) < NUM_OPS + 4 || DB_CYCLES < 1) begin : g_bad_params
    $error("param_control_unit: illegal parameter combination");
  end

  // Operand states OP_k occupy the encodings between OP0 and EXEC.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = STATE_W'(0),
    OPSEL = STATE_W'(1),
    OP0   = STATE_W'(2),
    EXEC  = STATE_W'(NUM_OPS + 2),
    DONE  = STATE_W'(NUM_OPS + 3)
  } state_t;

  state_t               state, state_n;
  logic                 reset_n, loadou_n, loadr_n;
  logic [NUM_OPS-1:0]   loadop_n;
  logic [1:0]           opcode_n;
  logic                 enter_lvl, back_lvl;
  logic                 enter_q, back_q;
  logic                 ent_ev, back_ev;
  logic [STATE_W-1:0]   op_idx;

`ifdef CU_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          enter_filt, back_filt;
  logic [CW-1:0] enter_cnt, back_cnt;

  // A filtered level flips only after the raw input disagrees for DB_CYCLES clocks in a row.
  always_ff @(posedge clk) begin
    if (CLR) begin
      enter_filt <= 1'b1;
      back_filt  <= 1'b1;
      enter_cnt  <= '0;
      back_cnt   <= '0;
    end else begin
      if (ENTER == enter_filt) begin
        enter_cnt <= '0;
      end else if (enter_cnt == CW'(DB_CYCLES - 1)) begin
        enter_filt <= ENTER;
        enter_cnt  <= '0;
      end else begin
        enter_cnt <= enter_cnt + 1'b1;
      end
      if (BACK == back_filt) begin
        back_cnt <= '0;
      end else if (back_cnt == CW'(DB_CYCLES - 1)) begin
        back_filt <= BACK;
        back_cnt  <= '0;
      end else begin
        back_cnt <= back_cnt + 1'b1;
      end
    end
  end

  assign enter_lvl = enter_filt;
  assign back_lvl  = back_filt;
`else
  assign enter_lvl = ENTER;
  assign back_lvl  = BACK;
`endif

  assign ent_ev  = enter_lvl & ~enter_q;
  assign back_ev = back_lvl & ~back_q;
  assign op_idx  = state - STATE_W'(2);

  // BACK takes priority over ENTER whenever both events land in the same cycle.
  always_comb begin
    state_n  = state;
    reset_n  = 1'b0;
    loadou_n = 1'b0;
    loadop_n = '0;
    loadr_n  = 1'b0;
    opcode_n = OpCode;
    case (state)
      IDLE: begin
        if (ent_ev && !back_ev) begin
          state_n = OPSEL;
          reset_n = 1'b1;
        end
      end
      OPSEL: begin
        if (back_ev) begin
          state_n = IDLE;
        end else if (ent_ev) begin
          state_n  = OP0;
          loadou_n = 1'b1;
          opcode_n = MODE;
        end
      end
      EXEC: begin
        state_n = DONE;
        loadr_n = 1'b1;
      end
      DONE: begin
        if (back_ev) begin
          state_n = IDLE;
        end else if (ent_ev) begin
          loadr_n = 1'b1;
        end
      end
      default: begin
        if (state >= OP0 && state < EXEC) begin
          if (back_ev) begin
            state_n = (state == OP0) ? OPSEL : state_t'(state - 1'b1);
          end else if (ent_ev) begin
            state_n = state_t'(state + 1'b1);
            for (int k = 0; k < NUM_OPS; k++) begin
              if (op_idx == STATE_W'(k)) loadop_n[k] = 1'b1;
            end
          end
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      state   <= IDLE;
      RESET   <= 1'b0;
      LoadOU  <= 1'b0;
      LoadOp  <= '0;
      LoadR   <= 1'b0;
      OpCode  <= 2'b00;
      enter_q <= 1'b1;
      back_q  <= 1'b1;
    end else begin
      state   <= state_n;
      RESET   <= reset_n;
      LoadOU  <= loadou_n;
      LoadOp  <= loadop_n;
      LoadR   <= loadr_n;
      OpCode  <= opcode_n;
      enter_q <= enter_lvl;
      back_q  <= back_lvl;
    end
  end

  assign LEDR = state;
  assign IUAU = (state == EXEC) || (state == DONE);
  assign Busy = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_param_control_unit.sv
// Directed self-checking bench for param_control_unit with NUM_OPS=3.
// Build with CU_DEBOUNCE_EN defined to exercise the debounce filter instead.
module tb_param_control_unit;
  localparam int NOPS = 3;
  localparam int SW   = 4;

  logic            clk = 1'b0;
  logic            CLR, ENTER, BACK;
  logic [1:0]      MODE;
  logic            RESET, LoadOU, LoadR, IUAU, Busy;
  logic [NOPS-1:0] LoadOp;
  logic [1:0]      OpCode;
  logic [SW-1:0]   LEDR;

  int checks = 0;
  int errors = 0;
  int cntReset, cntLoadOU, cntLoadR, multiHot;
  int cntLoadOp [NOPS];

  param_control_unit #(.NUM_OPS(NOPS), .STATE_W(SW), .DB_CYCLES(4)) dut (
    .clk(clk), .CLR(CLR), .ENTER(ENTER), .BACK(BACK), .MODE(MODE),
    .RESET(RESET), .LoadOU(LoadOU), .LoadOp(LoadOp), .LoadR(LoadR),
    .IUAU(IUAU), .OpCode(OpCode), .Busy(Busy), .LEDR(LEDR)
  );

  always #5 clk = ~clk;

  // Strobe occurrences are tallied mid-cycle; a stretched pulse counts twice.
  always @(negedge clk) begin
    cntReset  += int'(RESET);
    cntLoadOU += int'(LoadOU);
    cntLoadR  += int'(LoadR);
    for (int k = 0; k < NOPS; k++) cntLoadOp[k] += int'(LoadOp[k]);
    if (int'(RESET) + int'(LoadOU) + int'(LoadR) + $countones(LoadOp) > 1) multiHot++;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearCounts();
    cntReset = 0; cntLoadOU = 0; cntLoadR = 0;
    for (int k = 0; k < NOPS; k++) cntLoadOp[k] = 0;
  endtask

  task automatic press();
    ENTER = 1'b1; tick();
    ENTER = 1'b0; tick();
  endtask

  task automatic pressBack();
    BACK = 1'b1; tick();
    BACK = 1'b0; tick();
  endtask

  task automatic test_reset();
    CLR = 1'b1; ENTER = 1'b0; BACK = 1'b0; MODE = 2'b00;
    tick(2);
    checks++;
    if (LEDR !== 4'd0 || OpCode !== 2'd0 || IUAU !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: LEDR=%0d OpCode=%0d IUAU=%b Busy=%b, required 0 0 0 0", LEDR, OpCode, IUAU, Busy);
    end
    checks++;
    if ({RESET, LoadOU, LoadOp, LoadR} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got %b required 0", {RESET, LoadOU, LoadOp, LoadR});
    end
    CLR = 1'b0;
    tick();
    multiHot = 0;
    clearCounts();
  endtask

  task automatic test_sequence();
    clearCounts();
    press();
    checks++;
    if (LEDR !== 4'd1 || cntReset !== 1) begin
      errors++;
      $display("[TB] FAIL seq_opsel: LEDR=%0d RESET count=%0d, required 1 and 1", LEDR, cntReset);
    end
    MODE = 2'b10;
    press();
    MODE = 2'b01;
    checks++;
    if (LEDR !== 4'd2 || cntLoadOU !== 1 || OpCode !== 2'b10) begin
      errors++;
      $display("[TB] FAIL seq_op0: LEDR=%0d LoadOU count=%0d OpCode=%0d, required 2 1 2", LEDR, cntLoadOU, OpCode);
    end
    press();
    checks++;
    if (LEDR !== 4'd3 || cntLoadOp[0] !== 1 || cntLoadOp[1] !== 0) begin
      errors++;
      $display("[TB] FAIL seq_op1: LEDR=%0d LoadOp0 count=%0d LoadOp1 count=%0d, required 3 1 0", LEDR, cntLoadOp[0], cntLoadOp[1]);
    end
    press();
    checks++;
    if (LEDR !== 4'd4 || cntLoadOp[1] !== 1) begin
      errors++;
      $display("[TB] FAIL seq_op2: LEDR=%0d LoadOp1 count=%0d, required 4 1", LEDR, cntLoadOp[1]);
    end
    ENTER = 1'b1; tick();
    checks++;
    if (LEDR !== 4'd5 || LoadOp !== 3'b100 || IUAU !== 1'b1 || Busy !== 1'b1 || LoadR !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seq_exec: LEDR=%0d LoadOp=%b IUAU=%b Busy=%b LoadR=%b, required 5 100 1 1 0", LEDR, LoadOp, IUAU, Busy, LoadR);
    end
    ENTER = 1'b0; tick();
    checks++;
    if (LEDR !== 4'd6 || LoadR !== 1'b1 || LoadOp !== 3'b000) begin
      errors++;
      $display("[TB] FAIL seq_done_entry: LEDR=%0d LoadR=%b LoadOp=%b, required 6 1 000", LEDR, LoadR, LoadOp);
    end
    tick();
    checks++;
    if (LEDR !== 4'd6 || cntLoadR !== 1 || OpCode !== 2'b10 || IUAU !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seq_done: LEDR=%0d LoadR count=%0d OpCode=%0d IUAU=%b Busy=%b, required 6 1 2 1 0", LEDR, cntLoadR, OpCode, IUAU, Busy);
    end
    checks++;
    if (cntReset !== 1 || cntLoadOU !== 1 || cntLoadOp[2] !== 1) begin
      errors++;
      $display("[TB] FAIL seq_counts: RESET=%0d LoadOU=%0d LoadOp2=%0d, required 1 1 1", cntReset, cntLoadOU, cntLoadOp[2]);
    end
  endtask

  task automatic test_done_chain();
    clearCounts();
    press();
    press();
    checks++;
    if (cntLoadR !== 2 || LEDR !== 4'd6) begin
      errors++;
      $display("[TB] FAIL done_chain: LoadR count=%0d LEDR=%0d, required 2 6", cntLoadR, LEDR);
    end
    pressBack();
    checks++;
    if (LEDR !== 4'd0 || IUAU !== 1'b0 || Busy !== 1'b0 || cntLoadR !== 2 || cntReset !== 0) begin
      errors++;
      $display("[TB] FAIL done_back: LEDR=%0d IUAU=%b Busy=%b LoadR=%0d RESET=%0d, required 0 0 0 2 0", LEDR, IUAU, Busy, cntLoadR, cntReset);
    end
  endtask

  task automatic test_held_enter();
    press();
    clearCounts();
    ENTER = 1'b1;
    tick(10);
    checks++;
    if (LEDR !== 4'd2 || cntLoadOU !== 1 || cntLoadOp[0] !== 0 || cntLoadR !== 0 || cntReset !== 0) begin
      errors++;
      $display("[TB] FAIL held_enter: LEDR=%0d LoadOU=%0d LoadOp0=%0d, required 2 1 0", LEDR, cntLoadOU, cntLoadOp[0]);
    end
    ENTER = 1'b0; tick();
    press();
    checks++;
    if (LEDR !== 4'd3 || cntLoadOp[0] !== 1) begin
      errors++;
      $display("[TB] FAIL held_release: LEDR=%0d LoadOp0=%0d, required 3 1", LEDR, cntLoadOp[0]);
    end
  endtask

  task automatic test_back();
    int total;
    clearCounts();
    ENTER = 1'b1; BACK = 1'b1; tick();
    ENTER = 1'b0; BACK = 1'b0; tick();
    total = cntLoadOp[0] + cntLoadOp[1] + cntLoadOp[2];
    checks++;
    if (LEDR !== 4'd2 || total !== 0) begin
      errors++;
      $display("[TB] FAIL simultaneous: LEDR=%0d LoadOp count=%0d, required 2 0", LEDR, total);
    end
    press(); press();
    pressBack();
    checks++;
    if (LEDR !== 4'd3) begin
      errors++;
      $display("[TB] FAIL back_op2: LEDR=%0d required 3", LEDR);
    end
    pressBack(); pressBack();
    checks++;
    if (LEDR !== 4'd1) begin
      errors++;
      $display("[TB] FAIL back_op0: LEDR=%0d required 1", LEDR);
    end
    clearCounts();
    pressBack();
    checks++;
    if (LEDR !== 4'd0 || cntReset + cntLoadOU + cntLoadR !== 0) begin
      errors++;
      $display("[TB] FAIL back_opsel: LEDR=%0d strobes=%0d, required 0 0", LEDR, cntReset + cntLoadOU + cntLoadR);
    end
    pressBack();
    checks++;
    if (LEDR !== 4'd0) begin
      errors++;
      $display("[TB] FAIL back_idle: LEDR=%0d required 0", LEDR);
    end
  endtask

  task automatic test_clr();
    int total;
    CLR = 1'b1; ENTER = 1'b1; tick();
    CLR = 1'b0; clearCounts();
    tick(3);
    checks++;
    if (LEDR !== 4'd0 || cntReset !== 0) begin
      errors++;
      $display("[TB] FAIL clr_held_enter: LEDR=%0d RESET count=%0d, required 0 0", LEDR, cntReset);
    end
    ENTER = 1'b0; tick();
    press();
    MODE = 2'b11;
    press();
    checks++;
    if (LEDR !== 4'd2 || OpCode !== 2'b11) begin
      errors++;
      $display("[TB] FAIL clr_setup: LEDR=%0d OpCode=%0d, required 2 3", LEDR, OpCode);
    end
    clearCounts();
    CLR = 1'b1; ENTER = 1'b1; tick();
    checks++;
    if (LEDR !== 4'd0 || OpCode !== 2'b00 || LoadOp !== 3'b000) begin
      errors++;
      $display("[TB] FAIL clr_midop: LEDR=%0d OpCode=%0d LoadOp=%b, required 0 0 000", LEDR, OpCode, LoadOp);
    end
    CLR = 1'b0; ENTER = 1'b0; tick(2);
    total = cntLoadOp[0] + cntLoadOp[1] + cntLoadOp[2];
    checks++;
    if (LEDR !== 4'd0 || total !== 0) begin
      errors++;
      $display("[TB] FAIL clr_no_pulse: LEDR=%0d LoadOp count=%0d, required 0 0", LEDR, total);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (multiHot !== 0) begin
      errors++;
      $display("[TB] FAIL exclusivity: %0d multi-strobe cycles, required 0", multiHot);
    end
  endtask

  task automatic test_debounce();
    int first;
    tick(8);
    clearCounts();
    ENTER = 1'b1; tick(3);
    ENTER = 1'b0; tick(8);
    checks++;
    if (LEDR !== 4'd0 || cntReset !== 0) begin
      errors++;
      $display("[TB] FAIL db_glitch: LEDR=%0d RESET count=%0d, required 0 0", LEDR, cntReset);
    end
    first = 0;
    ENTER = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (RESET === 1'b1 && first == 0) first = i;
    end
    ENTER = 1'b0; tick(8);
    checks++;
    if (first !== 5) begin
      errors++;
      $display("[TB] FAIL db_latency: RESET at cycle %0d, required 5", first);
    end
    checks++;
    if (cntReset !== 1 || LEDR !== 4'd1) begin
      errors++;
      $display("[TB] FAIL db_press: RESET count=%0d LEDR=%0d, required 1 1", cntReset, LEDR);
    end
  endtask

  initial begin
    CLR = 1'b1; ENTER = 1'b0; BACK = 1'b0; MODE = 2'b00;
    test_reset();
`ifdef CU_DEBOUNCE_EN
    test_debounce();
`else
    test_sequence();
    test_done_chain();
    test_held_enter();
    test_back();
    test_clr();
`endif
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_control_unit.md
Name: param_control_unit

Overview:
- Parametrised successor to the lab calculator sequencer.
- Steps a datapath through operation select, NUM_OPS operand loads, execute and result display.
- Advances on rising edges of the ENTER button and adds a BACK step-back input.
- Drives one-cycle load strobes to the operand/opcode/result registers and exposes the state index on LEDs.

Parameters:
- NUM_OPS, 2, number of operand registers loaded in sequence (legal 1..8).
- STATE_W, 4, width of LEDR state index; must satisfy 2^STATE_W >= NUM_OPS+4.
- DB_CYCLES, 4, debounce stability count in clocks; used only when CU_DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- CLR  in  1  reset; synchronous, active-high.
- ENTER  in  1  advance button, level, already synchronised to clk.
- BACK  in  1  step-back button, level, already synchronised to clk.
- MODE  in  2  operation select switches, sampled on opcode load.
- RESET  out  1  one-cycle pulse, clears datapath registers.
- LoadOU  out  1  one-cycle pulse, loads opcode register.
- LoadOp  out  NUM_OPS  one-hot one-cycle pulse, bit k loads operand k.
- LoadR  out  1  one-cycle pulse, loads result register.
- IUAU  out  1  level, selects result path onto display.
- OpCode  out  2  latched MODE.
- Busy  out  1  level, high in every state except IDLE and DONE.
- LEDR  out  STATE_W  current state index, zero-extended.

Behaviour:
- Edge detect:
  - ent_ev = ENTER & ~enter_q; back_ev = BACK & ~back_q.
  - enter_q and back_q are registered copies of the inputs. CLR sets both to 1, so a button held through reset produces no event.
- State indices:
  - IDLE = 0, OPSEL = 1, OP_k = 2+k (k = 0..NUM_OPS-1), EXEC = NUM_OPS+2, DONE = NUM_OPS+3.
  - LEDR shows the current index.
- Transitions on an event at clock edge t: the state changes at t, and any pulse is high for exactly the cycle following t.
  - IDLE, ent_ev: go to OPSEL, pulse RESET.
  - OPSEL, ent_ev: go to OP_0, pulse LoadOU, OpCode <= MODE.
  - OP_k, ent_ev: pulse LoadOp[k]. Next state is OP_{k+1}, or EXEC when k = NUM_OPS-1.
  - EXEC: unconditional, one cycle. Go to DONE and pulse LoadR. ENTER and BACK are ignored, but enter_q/back_q still track the inputs.
  - DONE, ent_ev: stay in DONE, pulse LoadR again (chained recompute).
- BACK handling (back_ev):
  - OPSEL goes to IDLE.
  - OP_0 goes to OPSEL.
  - OP_k (k > 0) goes to OP_{k-1}.
  - DONE goes to IDLE.
  - Ignored in IDLE and EXEC.
  - BACK never produces a strobe.
- Simultaneous ent_ev and back_ev: BACK wins, the ENTER event is discarded.
- IUAU is high in EXEC and DONE, low elsewhere.
- Busy = (state != IDLE) && (state != DONE).
- Pulse exclusivity: at most one of RESET, LoadOU, LoadOp[*], LoadR is high in any cycle.
- Reset values: state = IDLE, OpCode = 0, all strobes = 0, IUAU = 0, Busy = 0, LEDR = 0.
- CLR mid-operation: the state returns to IDLE at the next clk edge. Any pulse due that cycle is suppressed, and OpCode clears.
- Unused state encodings: recover to IDLE on the next clock with no strobes.

Optional Feature:
- CU_DEBOUNCE_EN defined:
  - ENTER and BACK each pass through a filter. The filtered level changes only after the raw input holds a new value for DB_CYCLES consecutive clocks.
  - Edge detect operates on the filtered levels, adding DB_CYCLES cycles of event latency.
  - CLR sets both filtered levels to 1 and their counters to 0.
- CU_DEBOUNCE_EN undefined: raw ENTER/BACK feed edge detect directly, with 1-cycle event latency. DB_CYCLES is unused.

Test Plan:
- NUM_OPS=2, no debounce. ENTER pulses ×4 with MODE=2'b10 at the second:
  - RESET, LoadOU, LoadOp=01, LoadOp=10 each pulse once, 1 cycle wide.
  - EXEC lasts 1 cycle, then LoadR pulses. LEDR ends at 5, OpCode=2, IUAU=1, Busy=0.
- NUM_OPS=3, ENTER held high for 10 cycles in OPSEL: exactly one LoadOU pulse and state OP_0 (LEDR=2); no further strobes until ENTER is released and pressed again.
- In OP_1, ENTER and BACK rise in the same cycle: state becomes OP_0 (LEDR=2) and no LoadOp pulse occurs.
- In DONE, ENTER pressed twice: LoadR pulses twice and LEDR stays at NUM_OPS+3. Then BACK: LEDR=0, IUAU=0.
- ENTER held high across CLR deassertion, then CLR asserted in OP_0 during an ENTER edge:
  - After reset deassertion, no event occurs while ENTER stays high.
  - The CLR case returns to IDLE, OpCode=0, and no LoadOp pulse occurs.
- CU_DEBOUNCE_EN, DB_CYCLES=4: a 3-cycle ENTER glitch produces no event. A 6-cycle press produces one RESET pulse, appearing 5 cycles after the press starts.
